rtmc_spi_reg_bridge: RTL and testbench

SPI peripheral front end that converts host SPI frames into register-bus transactions. It consumes the SPI peripheral pins (sclk, cs, mosi in; miso out) and drives the register-bus initiator side (addr, wdat, wr, rd out; rdat, ack in) into the register file. SCLK is oversampled by the system clock, and the block supports auto-increment bursts.

---
 rtl/rtmc_pkg.sv | 20 ++
 rtl/rtmc_sync_edge.sv | 36 +++
 rtl/rtmc_spi_reg_bridge.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rtmc_spi_reg_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtmc_pkg.sv
// Shared constants and state encodings for the SPI register bridge.
package rtmc_pkg;

    localparam int SPI_CMD_BITS   = 8;
    localparam int SPI_CMD_WR_BIT = 7;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_CMD,
        FS_ADDR,
        FS_DATA
    } frame_state_t;

    typedef enum logic [1:0] {
        BS_IDLE,
        BS_WR,
        BS_RD
    } bus_state_t;

endpackage

// File: rtl/rtmc_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with registered
// single-cycle rise/fall pulses.
module rtmc_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_dly  <= RST_VAL;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_dly  <= r_sync;
            o_rise <= r_sync & ~r_dly;
            o_fall <= ~r_sync & r_dly;
        end
    end

    assign o_lvl = r_sync;

endmodule

// File: rtl/rtmc_spi_reg_bridge.sv
// SPI mode-0 peripheral that turns host frames into register-bus
// reads/writes with auto-increment bursts and read prefetch.
module rtmc_spi_reg_bridge
    import rtmc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdat,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdat,
    input  logic              reg_ack,
    output logic              busy,
    output logic              err
);

    localparam int CNT_MAX = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(SPI_CMD_BITS - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

    frame_state_t r_fs;
    frame_state_t w_fs_nxt;
    bus_state_t   r_bs;
    bus_state_t   w_bs_nxt;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;
    logic w_sclk_lvl_unused;
    logic w_cs_lvl_unused;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;

    logic w_rise;
    logic w_fall;
    logic w_cmd_done;
    logic w_addr_done;
    logic w_word_done;
    logic w_word_start;
    logic w_rd_now;
    logic w_issue_rd;
    logic w_issue_wr;
    logic w_rd_ack;

    logic [DATA_W-1:0] w_sh_nxt;
    logic [ADDR_W-1:0] w_rd_addr;

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_sh;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_miso_sh;
    logic [DATA_W-1:0] r_wdat;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_bus_addr;
    logic              r_wr_mode;
    logic              r_hold_vld;
    logic              r_drop;
    logic              r_rd_pend;
    logic              r_err;

    rtmc_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .i_d    (spi_sclk),
        .o_lvl  (w_sclk_lvl_unused),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    rtmc_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .i_d    (spi_cs),
        .o_lvl  (w_cs_lvl_unused),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    rtmc_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .i_d    (spi_mosi),
        .o_lvl  (w_mosi),
        .o_rise (w_mosi_rise_unused),
        .o_fall (w_mosi_fall_unused)
    );

    // A chip-select edge wins over an sclk edge in the same cycle
    assign w_rise       = w_sclk_rise & ~w_cs_rise & ~w_cs_fall;
    assign w_fall       = w_sclk_fall & ~w_cs_rise & ~w_cs_fall;
    assign w_sh_nxt     = {r_sh[DATA_W-2:0], w_mosi};
    assign w_word_start = w_fall && (r_fs == FS_DATA) && (r_cnt == '0);
    assign w_rd_now     = !r_wr_mode && (w_addr_done || w_word_start);
    assign w_issue_rd   = (r_bs == BS_IDLE) && (w_rd_now || r_rd_pend);
    assign w_issue_wr   = w_word_done && r_wr_mode && (r_bs == BS_IDLE);
    assign w_rd_addr    = w_addr_done ? w_sh_nxt[ADDR_W-1:0] : r_addr;
    assign w_rd_ack     = (r_bs == BS_RD) && reg_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fs <= FS_IDLE;
        end else begin
            r_fs <= w_fs_nxt;
        end
    end

    always_comb begin
        w_fs_nxt    = r_fs;
        w_cmd_done  = 1'b0;
        w_addr_done = 1'b0;
        w_word_done = 1'b0;
        if (w_cs_rise) begin
            w_fs_nxt = FS_IDLE;
        end else if (w_cs_fall) begin
            w_fs_nxt = FS_CMD;
        end else if (w_rise) begin
            unique case (r_fs)
                FS_CMD: begin
                    if (r_cnt == CMD_LAST) begin
                        w_cmd_done = 1'b1;
                        w_fs_nxt   = FS_ADDR;
                    end
                end
                FS_ADDR: begin
                    if (r_cnt == ADDR_LAST) begin
                        w_addr_done = 1'b1;
                        w_fs_nxt    = FS_DATA;
                    end
                end
                FS_DATA: w_word_done = (r_cnt == WORD_LAST);
                default: w_fs_nxt = r_fs;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_sh       <= '0;
            r_hold     <= '0;
            r_miso_sh  <= '0;
            r_addr     <= '0;
            r_wr_mode  <= 1'b0;
            r_hold_vld <= 1'b0;
            r_drop     <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_cs_rise || w_cs_fall) begin
                r_cnt <= '0;
            end else if (w_rise && r_fs != FS_IDLE) begin
                r_sh  <= w_sh_nxt;
                r_cnt <= (w_cmd_done || w_addr_done || w_word_done)
                       ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_cmd_done) begin
                r_wr_mode <= w_sh_nxt[SPI_CMD_WR_BIT];
            end
            if (w_rd_ack) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_drop <= 1'b0;
                if (!r_drop) begin
                    r_hold     <= reg_rdat;
                    r_hold_vld <= 1'b1;
                end
            end
            // Overrun drops the word but the burst address still advances
            if (w_word_done && r_wr_mode) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (r_bs != BS_IDLE) begin
                    r_err <= 1'b1;
                end
            end
            if (w_addr_done) begin
                r_addr <= w_sh_nxt[ADDR_W-1:0];
            end
            if (w_fall && r_fs == FS_DATA) begin
                if (r_cnt != '0) begin
                    r_miso_sh <= {r_miso_sh[DATA_W-2:0], 1'b0};
                end else if (r_wr_mode) begin
                    r_miso_sh <= '0;
                end else begin
                    r_miso_sh  <= r_hold_vld ? r_hold : '0;
                    r_hold_vld <= 1'b0;
                    if (!r_hold_vld) begin
                        r_err  <= 1'b1;
                        r_drop <= (r_bs == BS_RD) && !reg_ack;
                    end
                end
            end
            if (w_issue_rd) begin
                r_rd_pend <= 1'b0;
            end else if (w_rd_now) begin
                r_rd_pend <= 1'b1;
            end
            if (w_cs_rise) begin
                r_rd_pend <= 1'b0;
            end
            if (w_cs_fall) begin
                r_hold_vld <= 1'b0;
                r_drop     <= 1'b0;
                r_miso_sh  <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bs       <= BS_IDLE;
            r_bus_addr <= '0;
            r_wdat     <= '0;
        end else begin
            r_bs <= w_bs_nxt;
            if (w_issue_wr) begin
                r_bus_addr <= r_addr;
                r_wdat     <= w_sh_nxt;
            end else if (w_issue_rd) begin
                r_bus_addr <= w_rd_addr;
            end
        end
    end

    always_comb begin
        w_bs_nxt = r_bs;
        unique case (r_bs)
            BS_IDLE: begin
                if (w_issue_wr) begin
                    w_bs_nxt = BS_WR;
                end else if (w_issue_rd) begin
                    w_bs_nxt = BS_RD;
                end
            end
            BS_WR, BS_RD: begin
                if (reg_ack) begin
                    w_bs_nxt = BS_IDLE;
                end
            end
            default: w_bs_nxt = BS_IDLE;
        endcase
    end

    assign reg_addr = r_bus_addr;
    assign reg_wdat = r_wdat;
    assign reg_wr   = (r_bs == BS_WR);
    assign reg_rd   = (r_bs == BS_RD);
    assign busy     = (r_fs != FS_IDLE) || (r_bs != BS_IDLE);
    assign err      = r_err;
    assign spi_miso = (r_fs == FS_DATA) && r_miso_sh[DATA_W-1];

endmodule

// File: tb/tb_rtmc_spi_reg_bridge.sv
// Directed bench for the SPI register bridge: host SPI driver, register
// responder model and expectation queues.
module tb_rtmc_spi_reg_bridge;

    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdat;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] reg_rdat = 16'h0;
    logic        reg_ack = 1'b0;
    logic        busy;
    logic        err;

    rtmc_spi_reg_bridge #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_sclk (spi_sclk),
        .spi_cs   (spi_cs),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .reg_addr (reg_addr),
        .reg_wdat (reg_wdat),
        .reg_wr   (reg_wr),
        .reg_rd   (reg_rd),
        .reg_rdat (reg_rdat),
        .reg_ack  (reg_ack),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [23:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [15:0] exp_miso[$];
    logic [15:0] mem [256];

    int resp_delay = 2;
    bit late_once = 1'b0;
    int r_cnt = 0;
    int wr_len = 0;
    int last_wr_len = 0;
    int n_wr = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Register responder: acks after a programmable delay
    always @(negedge clk) begin
        logic [23:0] ew;
        logic [7:0]  ea;
        int d;
        reg_ack = 1'b0;
        if (err) n_err++;
        if (reg_wr) wr_len++;
        else if (wr_len != 0) begin
            last_wr_len = wr_len;
            wr_len = 0;
        end
        if (rst || !(reg_wr || reg_rd)) begin
            r_cnt = 0;
        end else begin
            if (r_cnt == 0) begin
                if (reg_wr) begin
                    n_wr++;
                    if (exp_wr.size() > 0) ew = exp_wr.pop_front();
                    else ew = 24'hxxxxxx;
                    check("wr_txn", {reg_addr, reg_wdat}, ew);
                end else begin
                    if (exp_rd.size() > 0) ea = exp_rd.pop_front();
                    else ea = 8'hxx;
                    check("rd_addr", reg_addr, ea);
                end
            end
            r_cnt++;
            d = (late_once && reg_rd) ? 8 : resp_delay;
            if (r_cnt >= d) begin
                reg_ack = 1'b1;
                if (reg_wr) mem[reg_addr] = reg_wdat;
                else begin
                    reg_rdat = mem[reg_addr];
                    late_once = 1'b0;
                end
                r_cnt = 0;
            end
        end
    end

    task automatic xfer(input logic [15:0] tx, input int n,
                        output logic [15:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (H) @(negedge clk);
            spi_sclk = 1'b1;
            rx = {rx[14:0], spi_miso};
            repeat (H) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [7:0] addr);
        logic [15:0] rx;
        spi_cs = 1'b0;
        repeat (H) @(negedge clk);
        xfer({8'h0, cmd}, 8, rx);
        check("miso_cmd", rx, 0);
        xfer({8'h0, addr}, 8, rx);
        check("miso_addr", rx, 0);
    endtask

    task automatic cs_high();
        repeat (H) @(negedge clk);
        spi_cs = 1'b1;
        repeat (4 * H) @(negedge clk);
    endtask

    task automatic rd_word(input string tag);
        logic [15:0] rx;
        logic [15:0] ex;
        xfer(16'h0, 16, rx);
        if (exp_miso.size() > 0) ex = exp_miso.pop_front();
        else ex = 16'hxxxx;
        check(tag, rx, ex);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rx;
        int w0;
        int e0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h3C00;
        mem[8'h34] = 16'hA5C3;

        repeat (3) @(negedge clk);
        check("reset_outs",
              {reg_wr, reg_rd, reg_addr, reg_wdat, busy, err, spi_miso}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single write
        w0 = n_wr; e0 = n_err; resp_delay = 2;
        exp_wr.push_back({8'h12, 16'hBEEF});
        send_hdr(8'h80, 8'h12);
        xfer(16'hBEEF, 16, rx);
        cs_high();
        check("t1_nwr", n_wr - w0, 1);
        check("t1_wrlen", last_wr_len, 2);
        check("t1_err", n_err - e0, 0);
        check("t1_mem", mem[8'h12], 16'hBEEF);

        // 2: single read plus prefetches
        e0 = n_err; resp_delay = 1;
        exp_rd.push_back(8'h34);
        exp_rd.push_back(8'h35);
        exp_rd.push_back(8'h36);
        exp_miso.push_back(16'hA5C3);
        send_hdr(8'h00, 8'h34);
        rd_word("t2_miso");
        cs_high();
        check("t2_rdq", exp_rd.size(), 0);
        check("t2_err", n_err - e0, 0);

        // 3: burst write wrapping past 0xFF
        w0 = n_wr; e0 = n_err; resp_delay = 2;
        exp_wr.push_back({8'hFE, 16'h1111});
        exp_wr.push_back({8'hFF, 16'h2222});
        exp_wr.push_back({8'h00, 16'h3333});
        send_hdr(8'h80, 8'hFE);
        xfer(16'h1111, 16, rx);
        xfer(16'h2222, 16, rx);
        xfer(16'h3333, 16, rx);
        cs_high();
        check("t3_nwr", n_wr - w0, 3);
        check("t3_wrq", exp_wr.size(), 0);
        check("t3_err", n_err - e0, 0);
        check("t3_mem00", mem[8'h00], 16'h3333);

        // 4: cs aborts mid-word
        w0 = n_wr; e0 = n_err;
        send_hdr(8'h80, 8'h50);
        xfer(16'hFFFF, 10, rx);
        repeat (H) @(negedge clk);
        check("t4_busy_mid", busy, 1);
        spi_cs = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_busy_sync", busy, 1);
        repeat (2) @(negedge clk);
        check("t4_busy_fall", busy, 0);
        repeat (4 * H) @(negedge clk);
        check("t4_nwr", n_wr - w0, 0);
        exp_wr.push_back({8'h60, 16'h1234});
        send_hdr(8'h80, 8'h60);
        xfer(16'h1234, 16, rx);
        cs_high();
        check("t4_nwr2", n_wr - w0, 1);
        check("t4_err", n_err - e0, 0);

        // 5: late ack on first read of a burst
        e0 = n_err; resp_delay = 1; late_once = 1'b1;
        exp_rd.push_back(8'h40);
        exp_rd.push_back(8'h41);
        exp_rd.push_back(8'h42);
        exp_rd.push_back(8'h43);
        exp_miso.push_back(16'h0000);
        exp_miso.push_back(mem[8'h41]);
        send_hdr(8'h00, 8'h40);
        rd_word("t5_miso0");
        rd_word("t5_miso1");
        cs_high();
        check("t5_err", n_err - e0, 1);
        check("t5_rdq", exp_rd.size(), 0);

        // 6: reset during ADDR with a write outstanding
        w0 = n_wr; resp_delay = 1000;
        exp_wr.push_back({8'h70, 16'hCAFE});
        send_hdr(8'h80, 8'h70);
        xfer(16'hCAFE, 16, rx);
        cs_high();
        check("t6_pend", {reg_wr, busy}, 2'b11);
        spi_cs = 1'b0;
        repeat (H) @(negedge clk);
        xfer(16'h0080, 8, rx);
        xfer(16'h0007, 4, rx);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        spi_cs = 1'b1;
        spi_sclk = 1'b0;
        @(negedge clk);
        check("t6_rst_outs",
              {reg_wr, reg_rd, reg_addr, reg_wdat, busy, err, spi_miso}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        resp_delay = 2;
        repeat (10) @(negedge clk);
        check("t6_mem70", mem[8'h70], 16'h3C00 ^ 16'h7070);
        exp_wr.push_back({8'h71, 16'h5A5A});
        send_hdr(8'h80, 8'h71);
        xfer(16'h5A5A, 16, rx);
        cs_high();
        check("t6_nwr", n_wr - w0, 2);
        check("t6_mem71", mem[8'h71], 16'h5A5A);

        check("end_wrq", exp_wr.size(), 0);
        check("end_misoq", exp_miso.size(), 0);
        check("end_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
